// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } ifetch_state_t;

   // Next-PC source selected at retirement
   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Instruction field positions (MIPS-style encoding)
   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;
   localparam int JTARGET_W = 26;

endpackage

// File: rtl/npc_sel32.sv
// rtl/npc_sel32.sv - next-PC priority select, target mux and jr alignment detect
module npc_sel32
   import ifetch_pkg::*;
(
   input  logic [31:0]          i_pc_plus_4,
   input  logic [JTARGET_W-1:0] i_jtarget,
   input  logic                 i_branch,
   input  logic                 i_nbranch,
   input  logic                 i_jmp,
   input  logic                 i_jal,
   input  logic                 i_jrn,
   input  logic                 i_zero,
   input  logic [31:0]          i_add_result,
   input  logic [31:0]          i_read_data_1,
   output logic [31:0]          o_next_pc,
   output logic                 o_jr_misalign
);

   npc_sel_t w_sel;
   logic     w_br_taken;

   // Priority encode the control decisions: jr, taken branch, jump, sequential
   always_comb begin
      w_br_taken = (i_branch & i_zero) | (i_nbranch & ~i_zero);
      w_sel      = NPC_SEQ;
      if (i_jrn)
         w_sel = NPC_JR;
      else if (w_br_taken)
         w_sel = NPC_BR;
      else if (i_jmp | i_jal)
         w_sel = NPC_J;
   end

   // Steer the selected target; jr drops the low two bits to stay word aligned
   always_comb begin
      o_next_pc = i_pc_plus_4;
      case (w_sel)
         NPC_JR:  o_next_pc = {i_read_data_1[31:2], 2'b00};
         NPC_BR:  o_next_pc = i_add_result;
         NPC_J:   o_next_pc = {i_pc_plus_4[31:28], i_jtarget, 2'b00};
         default: o_next_pc = i_pc_plus_4;
      endcase
   end

   // A jr through a register that is not word aligned is flagged
   always_comb begin
      o_jr_misalign = (w_sel == NPC_JR) && (i_read_data_1[1:0] != 2'b00);
   end

endmodule

// File: rtl/instr_fetch32.sv
// rtl/instr_fetch32.sv - multi-cycle instruction fetch stage with PC and next-PC logic
module instr_fetch32
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = 14
)
(
   input  logic              clock,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic [31:0]       Instruction,
   output logic [5:0]        Opcode,
   output logic [5:0]        Function_opcode,
   output logic              instr_valid,
   input  logic              advance,
   input  logic              Branch,
   input  logic              nBranch,
   input  logic              Jmp,
   input  logic              Jal,
   input  logic              Jrn,
   input  logic              Zero,
   input  logic [31:0]       Add_result,
   input  logic [31:0]       Read_data_1,
   output logic [31:0]       PC_plus_4,
   output logic [31:0]       link_addr,
   output logic [31:0]       pc_out,
   output logic              misalign,
   output logic [31:0]       instr_count
);

   ifetch_state_t r_state;
   ifetch_state_t w_state_nxt;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_req;
   logic        r_valid;
   logic        r_misalign;
   logic [31:0] r_count;

   logic [31:0] w_pc_plus_4;
   logic [31:0] w_next_pc;
   logic        w_jr_misalign;
   logic        w_fetch_done;
   logic        w_retire;

   // Sequencer state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_state <= BOOT;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic plus the qualified handshake events
   always_comb begin
      w_state_nxt  = r_state;
      w_fetch_done = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         BOOT:  w_state_nxt = FETCH;
         FETCH: begin
            w_fetch_done = imem_ready;
            if (imem_ready)
               w_state_nxt = VALID;
         end
         VALID: begin
            w_retire = advance;
            if (advance)
               w_state_nxt = FETCH;
         end
         default: w_state_nxt = BOOT;
      endcase
   end

   // Request line: raised on entry to FETCH, dropped once the word arrives
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_req <= 1'b0;
      else if ((r_state == BOOT) || w_retire)
         r_req <= 1'b1;
      else if (w_fetch_done)
         r_req <= 1'b0;
   end

   // Instruction latch and its valid flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_instr <= 32'h0000_0000;
         r_valid <= 1'b0;
      end else if (w_fetch_done) begin
         r_instr <= imem_rdata;
         r_valid <= 1'b1;
      end else if (w_retire) begin
         r_valid <= 1'b0;
      end
   end

   // PC, retirement counter and sticky jr-misalign flag update on retirement
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc       <= RESET_PC;
         r_count    <= 32'h0000_0000;
         r_misalign <= 1'b0;
      end else if (w_retire) begin
         r_pc    <= w_next_pc;
         r_count <= r_count + 32'd1;
         if (w_jr_misalign)
            r_misalign <= 1'b1;
      end
   end

   assign w_pc_plus_4 = r_pc + 32'd4;

   npc_sel32 u_npc_sel (
      .i_pc_plus_4   (w_pc_plus_4),
      .i_jtarget     (r_instr[JTARGET_W-1:0]),
      .i_branch      (Branch),
      .i_nbranch     (nBranch),
      .i_jmp         (Jmp),
      .i_jal         (Jal),
      .i_jrn         (Jrn),
      .i_zero        (Zero),
      .i_add_result  (Add_result),
      .i_read_data_1 (Read_data_1),
      .o_next_pc     (w_next_pc),
      .o_jr_misalign (w_jr_misalign)
   );

   assign imem_req        = r_req;
   assign imem_addr       = r_pc[ADDR_W+1:2];
   assign Instruction     = r_instr;
   assign Opcode          = r_instr[OPCODE_HI:OPCODE_LO];
   assign Function_opcode = r_instr[FUNCT_HI:FUNCT_LO];
   assign instr_valid     = r_valid;
   assign PC_plus_4       = w_pc_plus_4;
   assign link_addr       = w_pc_plus_4;
   assign pc_out          = r_pc;
   assign misalign        = r_misalign;
   assign instr_count     = r_count;

endmodule

// File: tb/tb_instr_fetch32.sv
// tb/tb_instr_fetch32.sv - directed self-checking bench for instr_fetch32
module tb_instr_fetch32;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [13:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_ready = 1'b0;
   logic [31:0] Instruction;
   logic [5:0]  Opcode;
   logic [5:0]  Function_opcode;
   logic        instr_valid;
   logic        advance = 1'b0;
   logic        Branch = 1'b0;
   logic        nBranch = 1'b0;
   logic        Jmp = 1'b0;
   logic        Jal = 1'b0;
   logic        Jrn = 1'b0;
   logic        Zero = 1'b0;
   logic [31:0] Add_result = 32'h0;
   logic [31:0] Read_data_1 = 32'h0;
   logic [31:0] PC_plus_4;
   logic [31:0] link_addr;
   logic [31:0] pc_out;
   logic        misalign;
   logic [31:0] instr_count;

   int          n_checks = 0;
   int          n_passed = 0;
   logic [31:0] exp_count = 32'h0;

   instr_fetch32 #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
      .clock           (clock),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .imem_ready      (imem_ready),
      .Instruction     (Instruction),
      .Opcode          (Opcode),
      .Function_opcode (Function_opcode),
      .instr_valid     (instr_valid),
      .advance         (advance),
      .Branch          (Branch),
      .nBranch         (nBranch),
      .Jmp             (Jmp),
      .Jal             (Jal),
      .Jrn             (Jrn),
      .Zero            (Zero),
      .Add_result      (Add_result),
      .Read_data_1     (Read_data_1),
      .PC_plus_4       (PC_plus_4),
      .link_addr       (link_addr),
      .pc_out          (pc_out),
      .misalign        (misalign),
      .instr_count     (instr_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Fetch one word with a given number of not-ready wait cycles; request must hold steady
   task automatic fetch(input logic [31:0] data, input int waits, input logic [13:0] exp_addr);
      for (int w = 0; w < waits; w++) begin
         imem_ready = 1'b0;
         chk("wait_req", {31'h0, imem_req}, 32'h1);
         chk("wait_addr", {18'h0, imem_addr}, {18'h0, exp_addr});
         chk("wait_valid", {31'h0, instr_valid}, 32'h0);
         @(posedge clock);
         @(negedge clock);
      end
      chk("fetch_req", {31'h0, imem_req}, 32'h1);
      chk("fetch_addr", {18'h0, imem_addr}, {18'h0, exp_addr});
      imem_ready = 1'b1;
      imem_rdata = data;
      @(posedge clock);
      @(negedge clock);
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("valid_up", {31'h0, instr_valid}, 32'h1);
      chk("instr", Instruction, data);
      chk("req_down", {31'h0, imem_req}, 32'h0);
   endtask

   // Retire the current instruction with the given control decisions
   task automatic retire(input logic br, input logic nbr, input logic j, input logic jl,
                         input logic jr, input logic z, input logic [31:0] add,
                         input logic [31:0] rd1, input logic [31:0] exp_pc);
      Branch = br; nBranch = nbr; Jmp = j; Jal = jl; Jrn = jr; Zero = z;
      Add_result = add; Read_data_1 = rd1;
      advance = 1'b1;
      @(posedge clock);
      @(negedge clock);
      advance = 1'b0;
      Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jrn = 1'b0; Zero = 1'b0;
      exp_count = exp_count + 32'd1;
      chk("pc", pc_out, exp_pc);
      chk("addr", {18'h0, imem_addr}, {18'h0, exp_pc[15:2]});
      chk("count", instr_count, exp_count);
      chk("ret_valid", {31'h0, instr_valid}, 32'h0);
      chk("ret_req", {31'h0, imem_req}, 32'h1);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", Instruction, 32'h0);
      chk("rst_opcode", {26'h0, Opcode}, 32'h0);
      chk("rst_funct", {26'h0, Function_opcode}, 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_count", instr_count, 32'h0);
      chk("rst_misalign", {31'h0, misalign}, 32'h0);
      chk("rst_pc4", PC_plus_4, 32'h4);

      // Release reset just after edge 1; request rises on edge 2
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("boot_req", {31'h0, imem_req}, 32'h0);
      @(posedge clock);
      @(negedge clock);

      // Zero-wait fetch of addi at word 0
      fetch(32'h2001_0005, 0, 14'h0);
      chk("opcode", {26'h0, Opcode}, 32'h08);
      chk("funct", {26'h0, Function_opcode}, 32'h05);
      retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);

      // Walk sequentially to PC 0x10
      fetch(32'h0000_0000, 0, 14'h1);
      retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8);
      fetch(32'h0000_0000, 1, 14'h2);
      retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC);
      fetch(32'h0000_0000, 0, 14'h3);
      retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10);

      // Three wait cycles at PC 0x10; a stray advance during FETCH is ignored
      advance = 1'b1;
      fetch(32'h1000_0003, 3, 14'h4);
      advance = 1'b0;
      chk("ign_adv_count", instr_count, exp_count);
      chk("ign_adv_pc", pc_out, 32'h10);

      // Branch taken, branch not taken, bne taken
      retire(1, 0, 0, 0, 0, 1, 32'h40, 32'h0, 32'h40);
      fetch(32'h1000_0003, 0, 14'h10);
      retire(1, 0, 0, 0, 0, 0, 32'h80, 32'h0, 32'h44);
      fetch(32'h1400_0003, 0, 14'h11);
      retire(0, 1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h40);

      // Jr wins over Jmp; misaligned source sets sticky flag
      fetch(32'h0800_0010, 0, 14'h10);
      chk("pre_misalign", {31'h0, misalign}, 32'h0);
      retire(0, 0, 1, 0, 1, 0, 32'h0, 32'h0000_0103, 32'h100);
      chk("misalign_set", {31'h0, misalign}, 32'h1);

      // Jr to 0x4000_0000, then jal with target field 0x10
      fetch(32'h0000_0008, 0, 14'h40);
      retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h4000_0000, 32'h4000_0000);
      fetch(32'h0C00_0010, 0, 14'h0);
      chk("link_addr", link_addr, 32'h4000_0004);
      retire(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h4000_0040);
      chk("misalign_sticky", {31'h0, misalign}, 32'h1);

      // PC wrap from 0xFFFF_FFFC
      fetch(32'h0000_0008, 0, 14'h10);
      retire(0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      fetch(32'h0000_0000, 0, 14'h3FFF);
      chk("wrap_pc4", PC_plus_4, 32'h0);
      retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

      // Reset asserted while FETCH waits; request dropped without a clock
      retire_prep: begin
         fetch(32'h0000_0000, 0, 14'h0);
         retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);
      end
      imem_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("arst_req", {31'h0, imem_req}, 32'h0);
      chk("arst_valid", {31'h0, instr_valid}, 32'h0);
      chk("arst_pc", pc_out, 32'h0);
      chk("arst_count", instr_count, 32'h0);
      chk("arst_misalign", {31'h0, misalign}, 32'h0);
      exp_count = 32'h0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("reboot_req", {31'h0, imem_req}, 32'h0);
      @(posedge clock);
      @(negedge clock);
      fetch(32'h2001_0005, 0, 14'h0);
      retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch32.md
# instr_fetch32

Multi-cycle instruction fetch stage for the Minisys-style 32-bit CPU. It holds the PC, fetches one word per instruction from a wait-state instruction memory over a req/ready handshake, and presents the instruction fields (Opcode, Function_opcode) to control32 and the decoder. On each retirement it selects the next PC from control32's Branch/nBranch/Jmp/Jal/Jrn decisions, the ALU Zero flag, the branch adder result and the jr source register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 14, instruction memory word-address width (16K words)

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  word address, PC[ADDR_W+1:2]
- imem_rdata  in  32  fetched word, valid when imem_ready=1
- imem_ready  in  1  memory accepts request and returns data this cycle
- Instruction  out  32  latched instruction word
- Opcode  out  6  Instruction[31:26], to control32
- Function_opcode  out  6  Instruction[5:0], to control32
- instr_valid  out  1  Instruction is valid and awaiting retirement
- advance  in  1  core retires current instruction this cycle
- Branch, nBranch, Jmp, Jal, Jrn  in  1 each  control32 decisions for the current instruction
- Zero  in  1  ALU zero flag
- Add_result  in  32  branch target byte address from execute
- Read_data_1  in  32  rs value for jr
- PC_plus_4  out  32  PC+4, combinational from PC
- link_addr  out  32  PC+4, written to $31 by Jal
- pc_out  out  32  current PC
- misalign  out  1  sticky: jr target had nonzero bits [1:0]
- instr_count  out  32  retired-instruction counter

## Operation
- States: BOOT, FETCH, VALID.
- BOOT: entered on reset; unconditionally moves to FETCH on the next clock.
- FETCH: imem_req=1, imem_addr=PC[ADDR_W+1:2]. When imem_ready=1: Instruction<=imem_rdata, instr_valid<=1, imem_req<=0, go to VALID. Otherwise stay in FETCH, request held stable.
- VALID: hold Instruction. When advance=1: PC<=next_pc, instr_valid<=0, imem_req<=1, instr_count<=instr_count+1, go to FETCH.
- next_pc priority, highest first:
  - Jrn: {Read_data_1[31:2], 2'b00}; sets misalign if Read_data_1[1:0]!=0.
  - (Branch & Zero) | (nBranch & ~Zero): Add_result.
  - Jmp | Jal: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
  - Otherwise: PC_plus_4.
- All PC arithmetic is 32-bit modulo 2^32. PC 32'hFFFF_FFFC+4 wraps to 0. imem_addr uses only PC[ADDR_W+1:2]; high bits are ignored, so the address aliases.
- Ignored inputs: advance outside VALID, imem_ready outside FETCH, and control inputs outside an advance cycle.
- instr_count wraps from 32'hFFFF_FFFF to 0. misalign clears only on reset.

## Timing
- Reset values: PC=RESET_PC, state=BOOT, imem_req=0, instr_valid=0, Instruction=0 (so Opcode=0 and Function_opcode=0), misalign=0, instr_count=0.
- imem_req, instr_valid and Instruction are registered. Opcode and Function_opcode are slices of the Instruction register.
- Zero-wait memory (imem_ready high on the first request cycle): instr_valid rises 1 clock after the FETCH cycle. An advance in the first VALID cycle gives 2 clocks per instruction.
- Each wait cycle of imem_ready adds 1 clock.
- First fetch after reset release: BOOT occupies 1 clock, so imem_req rises on the 2nd clock edge.
- Reset asserted mid-fetch or in VALID: the outstanding request is abandoned immediately (imem_req=0 asynchronously) and the PC is restored to RESET_PC.

## Structure
- Shared package ifetch_pkg holds:
  - state enum {BOOT, FETCH, VALID}
  - next-PC select enum {NPC_SEQ, NPC_BR, NPC_J, NPC_JR}
  - RESET_PC default
  - opcode field position constants
- One combinational sub-module, npc_sel32, implements the priority mux, the select code and the misalign detect. The FSM, PC, counter and latches stay in instr_fetch32.

## Test plan
- Reset, then zero-wait memory returning 32'h2001_0005 at word 0 → imem_req rises on the 2nd edge; Opcode=6'h08; instr_valid=1 one clock later; advance → imem_addr=1, instr_count=1.
- imem_ready held low 3 cycles at PC=0x10 → imem_req and imem_addr=4 stable; instr_valid stays 0 until the 4th cycle.
- Branch=1, Zero=1, Add_result=0x40 on advance → next imem_addr=0x10. Same stimulus with Zero=0 → PC=PC+4. nBranch=1, Zero=0 → PC=0x40.
- Jrn=1 and Jmp=1 together, Read_data_1=0x0000_0103 → PC=0x100 (Jrn wins), misalign=1 and stays 1. Jal with Instruction[25:0]=26'h10 at PC 0x4000_0000 → PC=0x4000_0040, link_addr=0x4000_0004.
- Reset asserted while FETCH waits on imem_ready → imem_req=0 and instr_valid=0 immediately; PC=RESET_PC; fetch restarts after BOOT.
- PC=32'hFFFF_FFFC, sequential advance → PC=0; imem_addr=0.
